ram_port_arbiter: RTL



---
 rtl/ram_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one byte-wide RAM port between fetch and load/store, serializing 1/2/4-byte accesses.
// Optional RAM_ARB_FAIR_EN: after two consecutive MEM grants with fetch pending, the next grant goes to IF.
module ram_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [16:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [16:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d, n_q, n_d;
  logic [1:0]  sz_q, sz_d;
  logic [31:0] wd_q, wd_d, asm_q, asm_d;
  logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic [16:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        grant_if, grant_mem;
  logic [4:0]  rd_sel, wr_sel;
  // k counts the address being driven; the byte arriving now belongs to address k-1
  assign rd_sel = {k_q[1:0] - 2'd1, 3'b000};
  assign wr_sel = {k_q[1:0] + 2'd1, 3'b000};
`ifdef RAM_ARB_FAIR_EN
  logic [1:0] fair_q, fair_d;
  assign grant_if = if_req && (!mem_req || fair_q == 2'd2);
`else
  assign grant_if = if_req && !mem_req;
`endif
  assign grant_mem = mem_req && !grant_if;
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    sz_d        = sz_q;
    wd_d        = wd_q;
    asm_d       = asm_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
`ifdef RAM_ARB_FAIR_EN
    fair_d      = fair_q;
`endif
    case (state_q)
      IDLE: begin
        k_d = 3'd0;
`ifdef RAM_ARB_FAIR_EN
        fair_d = grant_mem && if_req ? fair_q + 2'd1 : 2'd0;
`endif
        if (grant_mem) begin
          state_d     = mem_we ? MEM_WR : MEM_RD;
          n_d         = mem_size == 2'd3 ? 3'd4 : mem_size == 2'd2 ? 3'd2 : 3'd1;
          sz_d        = mem_size;
          wd_d        = mem_wdata;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata[7:0];
          ram_we_d    = mem_we;
        end else if (grant_if) begin
          state_d    = IF_RD;
          n_d        = 3'd4;
          ram_addr_d = if_addr;
        end
      end
      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && if_flush) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          if (k_q != 3'd0) asm_d[rd_sel +: 8] = ram_rdata;
          if (k_q == n_q) begin
            state_d     = DONE;
            k_d         = 3'd0;
            if_done_d   = state_q == IF_RD;
            mem_done_d  = state_q == MEM_RD;
            if_rdata_d  = state_q == IF_RD ? asm_d : if_rdata_q;
            mem_rdata_d = state_q == IF_RD ? mem_rdata_q :
                          sz_q == 2'd3 ? asm_d :
                          sz_q == 2'd2 ? {16'b0, asm_d[15:0]} : {24'b0, asm_d[7:0]};
          end else begin
            k_d        = k_q + 3'd1;
            ram_addr_d = k_q + 3'd1 < n_q ? ram_addr_q + 17'd1 : ram_addr_q;
          end
        end
      end
      MEM_WR: begin
        if (k_q + 3'd1 == n_q) begin
          state_d    = DONE;
          k_d        = 3'd0;
          mem_done_d = 1'b1;
        end else begin
          k_d         = k_q + 3'd1;
          ram_addr_d  = ram_addr_q + 17'd1;
          ram_wdata_d = wd_q[wr_sel +: 8];
          ram_we_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      sz_q        <= 2'd0;
      wd_q        <= 32'd0;
      asm_q       <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= 17'd0;
      ram_wdata_q <= 8'd0;
      ram_we_q    <= 1'b0;
`ifdef RAM_ARB_FAIR_EN
      fair_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      sz_q        <= sz_d;
      wd_q        <= wd_d;
      asm_q       <= asm_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
`ifdef RAM_ARB_FAIR_EN
      fair_q      <= fair_d;
`endif
    end
  end
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
endmodule
